// File: rtl/ddr3_init_pkg.sv
// Shared definitions for the DDR3 power-up sequencer: command encodings,
// step-ROM layout, JEDEC timing constants and cycle-conversion helpers.
package ddr3_init_pkg;

    typedef enum logic [3:0] {
        CMD_MRS = 4'b0000,
        CMD_REF = 4'b0001,
        CMD_ZQC = 4'b0110,
        CMD_NOP = 4'b0111
    } cmd_e;

    typedef enum logic [1:0] {
        ST_RESET,
        ST_STEP_LOAD,
        ST_STEP_WAIT,
        ST_DONE
    } state_e;

    // Step word: {use_timer, stay_cmd, cke, reset_n, cmd[3:0], payload[18:0]}
    localparam int unsigned PAYLOAD_W = 19;
    localparam int unsigned F_CMD_LSB = 19;
    localparam int unsigned F_RESET_N = 23;
    localparam int unsigned F_CKE     = 24;
    localparam int unsigned F_STAY    = 25;
    localparam int unsigned F_TIMER   = 26;
    localparam int unsigned STEP_W    = 27;

    localparam logic [3:0] LAST_STEP = 4'd8;
    localparam logic [3:0] DONE_STEP = 4'd9;

    localparam int unsigned CLK_RATIO         = 4;
    localparam int unsigned DRAM_DENSITY_GBIT = 1;
    localparam int unsigned INIT_RESET_NS     = 200_000;
    localparam int unsigned INIT_CKE_NS       = 500_000;
    localparam int unsigned T_XPR_MIN_NCK     = 5;
    localparam int unsigned T_XPR_EXTRA_NS    = 10;
    localparam int unsigned T_MOD_NCK         = 12;
    localparam int unsigned T_MOD_NS          = 15;
    localparam int unsigned T_ZQINIT_NCK      = 512;
    localparam int unsigned T_ZQINIT_NS       = 640;

    function automatic int unsigned t_rfc_ns(input int unsigned gbit);
        case (gbit)
            1:       return 110;
            2:       return 160;
            4:       return 260;
            default: return 350;
        endcase
    endfunction

    function automatic int unsigned ns_to_cycles(input int unsigned ns,
                                                 input int unsigned period_ps);
        longint unsigned ps;
        longint unsigned cyc;
        ps  = 64'(ns) * 64'd1000;
        cyc = (ps + 64'(period_ps) - 64'd1) / 64'(period_ps);
        return (cyc == 64'd0) ? 32'd1 : 32'(cyc);
    endfunction

    function automatic int unsigned nck_to_cycles(input int unsigned nck);
        int unsigned c;
        c = (nck + CLK_RATIO - 1) / CLK_RATIO;
        return (c == 0) ? 32'd1 : c;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [STEP_W-1:0] mk_step(input logic use_timer,
                                                  input logic stay_cmd,
                                                  input logic cke,
                                                  input logic reset_n,
                                                  input cmd_e cmd,
                                                  input logic [PAYLOAD_W-1:0] payload);
        logic [STEP_W-1:0] w;
        w                        = '0;
        w[F_TIMER]               = use_timer;
        w[F_STAY]                = stay_cmd;
        w[F_CKE]                 = cke;
        w[F_RESET_N]             = reset_n;
        w[F_CMD_LSB +: 4]        = cmd;
        w[PAYLOAD_W-1:0]         = payload;
        return w;
    endfunction

endpackage

// File: rtl/ddr3_refresh_tracker.sv
// Refresh interval timer with owed-refresh counter and sticky overflow flag.
module ddr3_refresh_tracker
    import ddr3_init_pkg::*;
#(
    parameter int unsigned T_REFI       = 1560,
    parameter int unsigned MAX_POSTPONE = 8,
    parameter int unsigned CNT_W        = 11
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_clr,
    input  logic       i_en,
    input  logic       i_ref_ack,
    output logic       o_ref_req,
    output logic [3:0] o_ref_pending,
    output logic       o_ref_overflow
);

    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_pending;
    logic             r_overflow;
    logic             r_req;
    logic             w_tick;
    logic             w_ack;
    logic [3:0]       w_pending_nxt;
    logic             w_overflow_nxt;

    assign w_tick = i_en && (r_cnt == CNT_W'(T_REFI - 1));
    assign w_ack  = i_ref_ack && (r_pending != '0);

    // A tick and an ack in the same cycle cancel out.
    always_comb begin
        w_pending_nxt  = r_pending;
        w_overflow_nxt = r_overflow;
        if (w_tick && !w_ack) begin
            if (r_pending == 4'(MAX_POSTPONE)) begin
                w_overflow_nxt = 1'b1;
            end else begin
                w_pending_nxt = r_pending + 4'd1;
            end
        end else if (w_ack && !w_tick) begin
            w_pending_nxt = r_pending - 4'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt      <= '0;
            r_pending  <= '0;
            r_overflow <= 1'b0;
            r_req      <= 1'b0;
        end else if (i_clr) begin
            r_cnt      <= '0;
            r_pending  <= '0;
            r_overflow <= 1'b0;
            r_req      <= 1'b0;
        end else begin
            r_cnt      <= (!i_en || w_tick) ? '0 : r_cnt + 1'b1;
            r_pending  <= w_pending_nxt;
            r_overflow <= w_overflow_nxt;
            r_req      <= (w_pending_nxt != '0);
        end
    end

    assign o_ref_req      = r_req;
    assign o_ref_pending  = r_pending;
    assign o_ref_overflow = r_overflow;

endmodule

// File: rtl/ddr3_init_sequencer.sv
// DDR3 power-up sequencer: walks a ROM of timed steps (RESET#, CKE, MRS, ZQCL),
// then flags init-done and hands periodic refresh tracking to the sub-block.
module ddr3_init_sequencer
    import ddr3_init_pkg::*;
#(
    parameter int unsigned CLK_PERIOD_PS = 5000,
    parameter int unsigned ROW_BITS      = 14,
    parameter int unsigned BA_BITS       = 3,
    parameter logic [18:0] MR0           = 19'h0,
    parameter logic [18:0] MR1           = 19'h0,
    parameter logic [18:0] MR2           = 19'h0,
    parameter logic [18:0] MR3           = 19'h0,
    parameter int unsigned INIT_SCALE    = 1,
    parameter int unsigned T_REFI_NS     = 7800,
    parameter int unsigned MAX_POSTPONE  = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_reinit,
    input  logic                i_ref_ack,
    output logic                o_ddr3_reset_n,
    output logic                o_ddr3_cke,
    output logic [3:0]          o_cmd,
    output logic [BA_BITS-1:0]  o_ba,
    output logic [ROW_BITS-1:0] o_addr,
    output logic                o_odt,
    output logic                o_init_done,
    output logic [3:0]          o_step,
    output logic                o_ref_req,
    output logic [3:0]          o_ref_pending,
    output logic                o_ref_overflow
);

    localparam int unsigned C_RESET_HOLD = ns_to_cycles(INIT_RESET_NS / INIT_SCALE, CLK_PERIOD_PS);
    localparam int unsigned C_CKE_WAIT   = ns_to_cycles(INIT_CKE_NS / INIT_SCALE, CLK_PERIOD_PS);
    localparam int unsigned C_TXPR       = max_u(nck_to_cycles(T_XPR_MIN_NCK),
        ns_to_cycles(t_rfc_ns(DRAM_DENSITY_GBIT) + T_XPR_EXTRA_NS, CLK_PERIOD_PS));
    localparam int unsigned C_TMOD       = max_u(nck_to_cycles(T_MOD_NCK),
        ns_to_cycles(T_MOD_NS, CLK_PERIOD_PS));
    localparam int unsigned C_TZQINIT    = max_u(nck_to_cycles(T_ZQINIT_NCK),
        ns_to_cycles(T_ZQINIT_NS, CLK_PERIOD_PS));
    localparam int unsigned T_REFI       = ns_to_cycles(T_REFI_NS, CLK_PERIOD_PS);
    localparam int unsigned REFI_W       = $clog2(T_REFI + 1);

    function automatic logic [STEP_W-1:0] rom(input logic [3:0] idx);
        case (idx)
            4'd0:    return mk_step(1'b1, 1'b1, 1'b0, 1'b0, CMD_NOP, PAYLOAD_W'(C_RESET_HOLD));
            4'd1:    return mk_step(1'b1, 1'b1, 1'b0, 1'b1, CMD_NOP, PAYLOAD_W'(C_CKE_WAIT));
            4'd2:    return mk_step(1'b1, 1'b1, 1'b1, 1'b1, CMD_NOP, PAYLOAD_W'(C_TXPR));
            4'd3:    return mk_step(1'b0, 1'b0, 1'b1, 1'b1, CMD_MRS, MR2);
            4'd4:    return mk_step(1'b0, 1'b0, 1'b1, 1'b1, CMD_MRS, MR3);
            4'd5:    return mk_step(1'b0, 1'b0, 1'b1, 1'b1, CMD_MRS, MR1);
            4'd6:    return mk_step(1'b0, 1'b0, 1'b1, 1'b1, CMD_MRS, MR0);
            4'd7:    return mk_step(1'b1, 1'b1, 1'b1, 1'b1, CMD_NOP, PAYLOAD_W'(C_TMOD));
            4'd8:    return mk_step(1'b1, 1'b0, 1'b1, 1'b1, CMD_ZQC, PAYLOAD_W'(C_TZQINIT));
            default: return mk_step(1'b0, 1'b1, 1'b1, 1'b1, CMD_NOP, '0);
        endcase
    endfunction

    state_e                 r_state;
    logic [3:0]             r_step;
    logic [PAYLOAD_W-1:0]   r_cnt;
    logic                   r_stay;
    logic                   r_reset_n;
    logic                   r_cke;
    cmd_e                   r_cmd;
    logic [BA_BITS-1:0]     r_ba;
    logic [ROW_BITS-1:0]    r_addr;
    logic                   r_init_done;

    logic [3:0]             w_next_idx;
    logic [STEP_W-1:0]      w_entry;
    logic [PAYLOAD_W-1:0]   w_payload;
    logic [PAYLOAD_W-1:0]   w_dur;
    cmd_e                   w_cmd;
    logic [BA_BITS-1:0]     w_ba;
    logic [ROW_BITS-1:0]    w_addr;
    logic                   w_in_step;
    logic                   w_expire;
    logic                   w_load;
    logic                   w_finish;
    logic                   w_unused_bits;

    assign w_in_step  = (r_state == ST_STEP_LOAD) || (r_state == ST_STEP_WAIT);
    assign w_expire   = w_in_step && (r_cnt == '0);
    assign w_load     = i_reinit || (r_state == ST_RESET) || (w_expire && (r_step != LAST_STEP));
    assign w_finish   = !i_reinit && w_expire && (r_step == LAST_STEP);
    assign w_next_idx = (i_reinit || (r_state == ST_RESET)) ? 4'd0 : r_step + 4'd1;

    assign w_entry       = rom(w_next_idx);
    assign w_payload     = w_entry[PAYLOAD_W-1:0];
    assign w_cmd         = cmd_e'(w_entry[F_CMD_LSB +: 4]);
    assign w_dur         = w_entry[F_TIMER] ? w_payload : PAYLOAD_W'(1);
    assign w_unused_bits = ^(w_payload >> ROW_BITS);

    // ZQCL carries no payload address; only A10 (long calibration) is driven.
    always_comb begin
        w_ba   = '0;
        w_addr = '0;
        if (w_cmd == CMD_MRS) begin
            w_ba   = w_payload[16 +: BA_BITS];
            w_addr = w_payload[ROW_BITS-1:0];
        end else if (w_cmd == CMD_ZQC) begin
            w_addr[10] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_RESET;
            r_step      <= '0;
            r_cnt       <= '0;
            r_stay      <= 1'b1;
            r_reset_n   <= 1'b0;
            r_cke       <= 1'b0;
            r_cmd       <= CMD_NOP;
            r_ba        <= '0;
            r_addr      <= '0;
            r_init_done <= 1'b0;
        end else if (w_load) begin
            r_state     <= ST_STEP_LOAD;
            r_step      <= w_next_idx;
            r_cnt       <= w_dur - PAYLOAD_W'(1);
            r_stay      <= w_entry[F_STAY];
            r_reset_n   <= w_entry[F_RESET_N];
            r_cke       <= w_entry[F_CKE];
            r_cmd       <= w_cmd;
            r_ba        <= w_ba;
            r_addr      <= w_addr;
            r_init_done <= 1'b0;
        end else if (w_finish) begin
            r_state     <= ST_DONE;
            r_step      <= DONE_STEP;
            r_reset_n   <= 1'b1;
            r_cke       <= 1'b1;
            r_cmd       <= CMD_NOP;
            r_ba        <= '0;
            r_addr      <= '0;
            r_init_done <= 1'b1;
        end else if (w_in_step) begin
            r_state <= ST_STEP_WAIT;
            r_cnt   <= r_cnt - PAYLOAD_W'(1);
            if ((r_state == ST_STEP_LOAD) && !r_stay) begin
                r_cmd  <= CMD_NOP;
                r_ba   <= '0;
                r_addr <= '0;
            end
        end
    end

    ddr3_refresh_tracker #(
        .T_REFI       (T_REFI),
        .MAX_POSTPONE (MAX_POSTPONE),
        .CNT_W        (REFI_W)
    ) u_refresh (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_clr          (i_reinit),
        .i_en           (r_init_done),
        .i_ref_ack      (i_ref_ack),
        .o_ref_req      (o_ref_req),
        .o_ref_pending  (o_ref_pending),
        .o_ref_overflow (o_ref_overflow)
    );

    assign o_ddr3_reset_n = r_reset_n;
    assign o_ddr3_cke     = r_cke;
    assign o_cmd          = r_cmd;
    assign o_ba           = r_ba;
    assign o_addr         = r_addr;
    assign o_odt          = 1'b0;
    assign o_init_done    = r_init_done;
    assign o_step         = r_step;

endmodule

// File: tb/tb_ddr3_init_sequencer.sv
// Scoreboard bench: expected output segments and refresh events are queued by
// the stimulus; monitors pop and compare whenever the DUT outputs change.
module tb_ddr3_init_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        reinit;
    logic        ref_ack;
    logic        ddr3_reset_n, ddr3_cke, odt, init_done, ref_req, ref_overflow;
    logic [3:0]  cmd, step, ref_pending;
    logic [2:0]  ba;
    logic [13:0] addr;

    always #5 clk = ~clk;

    ddr3_init_sequencer #(
        .CLK_PERIOD_PS (5000),
        .ROW_BITS      (14),
        .BA_BITS       (3),
        .MR0           (19'h01D70),
        .MR1           (19'h10044),
        .MR2           (19'h20008),
        .MR3           (19'h30004),
        .INIT_SCALE    (100),
        .T_REFI_NS     (7800),
        .MAX_POSTPONE  (8)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_reinit       (reinit),
        .i_ref_ack      (ref_ack),
        .o_ddr3_reset_n (ddr3_reset_n),
        .o_ddr3_cke     (ddr3_cke),
        .o_cmd          (cmd),
        .o_ba           (ba),
        .o_addr         (addr),
        .o_odt          (odt),
        .o_init_done    (init_done),
        .o_step         (step),
        .o_ref_req      (ref_req),
        .o_ref_pending  (ref_pending),
        .o_ref_overflow (ref_overflow)
    );

    typedef struct packed {
        logic [3:0]  step;
        logic        rst_n;
        logic        cke;
        logic [3:0]  cmd;
        logic [2:0]  ba;
        logic [13:0] addr;
        logic        odt;
        logic        done;
    } seg_t;

    typedef struct {
        seg_t        v;
        int unsigned len;
    } seg_exp_t;

    typedef struct {
        logic [5:0]  v;   // {req, pending[3:0], overflow}
        int unsigned rel;
    } ref_exp_t;

    int checks = 0;
    int errors = 0;
    seg_exp_t seg_q[$];
    ref_exp_t ref_q[$];
    logic seg_en = 1'b0;
    int unsigned cur = 0;

    function automatic seg_t mk_seg(input logic [3:0] s, input logic rn, input logic ck,
                                    input logic [3:0] c, input logic [2:0] b,
                                    input logic [13:0] a, input logic d);
        seg_t r;
        r = '{step: s, rst_n: rn, cke: ck, cmd: c, ba: b, addr: a, odt: 1'b0, done: d};
        return r;
    endfunction

    task automatic push_seg(input seg_t v, input int unsigned len);
        seg_exp_t e;
        e.v = v;
        e.len = len;
        seg_q.push_back(e);
    endtask

    task automatic push_ref(input logic req, input logic [3:0] pend, input logic ovf,
                            input int unsigned rel);
        ref_exp_t e;
        e.v = {req, pend, ovf};
        e.rel = rel;
        ref_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic goto_cycle(input int unsigned c);
        repeat (c - cur) @(posedge clk);
        cur = c;
        #1;
    endtask

    // Segment monitor: a segment is a run of identical sequencer outputs.
    seg_t        seg_cur;
    int unsigned seg_len = 0;
    logic        seg_active = 1'b0;

    always @(negedge clk) begin
        seg_t v;
        seg_exp_t e;
        v = mk_seg(step, ddr3_reset_n, ddr3_cke, cmd, ba, addr, init_done);
        v.odt = odt;
        if (!seg_en) begin
            seg_active = 1'b0;
        end else if (!seg_active) begin
            seg_cur = v;
            seg_len = 1;
            seg_active = 1'b1;
        end else if (v === seg_cur) begin
            seg_len++;
        end else begin
            checks++;
            if (seg_q.size() == 0) begin
                errors++;
                $display("FAIL seg_unexpected: got %h len %0d", seg_cur, seg_len);
            end else begin
                e = seg_q.pop_front();
                if (seg_cur !== e.v || seg_len != e.len) begin
                    errors++;
                    $display("FAIL seg_step%0d: got %h len %0d expected %h len %0d",
                             e.v.step, seg_cur, seg_len, e.v, e.len);
                end
            end
            seg_cur = v;
            seg_len = 1;
        end
    end

    // Refresh monitor: cycle index is relative to the rise of init_done.
    int unsigned rel = 0;
    logic        prev_done = 1'b0;
    logic [5:0]  prev_rv = '0;

    always @(negedge clk) begin
        logic [5:0] rv;
        ref_exp_t e;
        if (init_done === 1'b1 && prev_done !== 1'b1) rel = 0;
        else rel++;
        prev_done = init_done;
        rv = {ref_req, ref_pending, ref_overflow};
        if (rv !== prev_rv) begin
            checks++;
            if (ref_q.size() == 0) begin
                errors++;
                $display("FAIL ref_unexpected: got %b at cycle %0d", rv, rel);
            end else begin
                e = ref_q.pop_front();
                if (rv !== e.v || rel != e.rel) begin
                    errors++;
                    $display("FAIL ref_event: got %b at cycle %0d expected %b at cycle %0d",
                             rv, rel, e.v, e.rel);
                end
            end
        end
        prev_rv = rv;
    end

    initial begin
        int guard;
        logic ok;
        rst_n = 1'b0;
        reinit = 1'b0;
        ref_ack = 1'b0;
        ok = 1'b1;

        @(negedge clk);
        chk("rst_reset_n", 32'(ddr3_reset_n), 32'h0);
        chk("rst_cke", 32'(ddr3_cke), 32'h0);
        chk("rst_cmd", 32'(cmd), 32'h7);
        chk("rst_ba", 32'(ba), 32'h0);
        chk("rst_addr", 32'(addr), 32'h0);
        chk("rst_odt", 32'(odt), 32'h0);
        chk("rst_init_done", 32'(init_done), 32'h0);
        chk("rst_step", 32'(step), 32'h0);
        chk("rst_ref_req", 32'(ref_req), 32'h0);
        chk("rst_ref_pending", 32'(ref_pending), 32'h0);
        chk("rst_ref_overflow", 32'(ref_overflow), 32'h0);
        #2 rst_n = 1'b1;

        guard = 0;
        while (step !== 4'd1 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (step !== 4'd1) begin
            chk("reach_step1", 32'(step), 32'h1);
            ok = 1'b0;
        end

        if (ok) begin
            // Reinit lands on step 1's second cycle; full sequence follows.
            push_seg(mk_seg(4'd1, 1'b1, 1'b0, 4'h7, 3'd0, 14'h0000, 1'b0), 1);
            push_seg(mk_seg(4'd0, 1'b0, 1'b0, 4'h7, 3'd0, 14'h0000, 1'b0), 400);
            push_seg(mk_seg(4'd1, 1'b1, 1'b0, 4'h7, 3'd0, 14'h0000, 1'b0), 1000);
            push_seg(mk_seg(4'd2, 1'b1, 1'b1, 4'h7, 3'd0, 14'h0000, 1'b0), 24);
            push_seg(mk_seg(4'd3, 1'b1, 1'b1, 4'h0, 3'd2, 14'h0008, 1'b0), 1);
            push_seg(mk_seg(4'd4, 1'b1, 1'b1, 4'h0, 3'd3, 14'h0004, 1'b0), 1);
            push_seg(mk_seg(4'd5, 1'b1, 1'b1, 4'h0, 3'd1, 14'h0044, 1'b0), 1);
            push_seg(mk_seg(4'd6, 1'b1, 1'b1, 4'h0, 3'd0, 14'h1D70, 1'b0), 1);
            push_seg(mk_seg(4'd7, 1'b1, 1'b1, 4'h7, 3'd0, 14'h0000, 1'b0), 3);
            push_seg(mk_seg(4'd8, 1'b1, 1'b1, 4'h6, 3'd0, 14'h0400, 1'b0), 1);
            push_seg(mk_seg(4'd8, 1'b1, 1'b1, 4'h7, 3'd0, 14'h0000, 1'b0), 127);
            @(posedge clk);
            #1;
            reinit = 1'b1;
            seg_en = 1'b1;
            @(posedge clk);
            #1;
            reinit = 1'b0;

            guard = 0;
            while (init_done !== 1'b1 && guard < 3000) begin
                @(negedge clk);
                guard++;
            end
            if (init_done !== 1'b1) begin
                chk("reach_done", 32'(init_done), 32'h1);
                ok = 1'b0;
            end
        end

        if (ok) begin
            cur = 0;
            for (int k = 1; k <= 8; k++) push_ref(1'b1, 4'(k), 1'b0, 32'(k) * 1560);
            push_ref(1'b1, 4'd8, 1'b1, 14040);

            goto_cycle(100);
            ref_ack = 1'b1;
            goto_cycle(101);
            ref_ack = 1'b0;

            goto_cycle(14100);
            push_ref(1'b1, 4'd7, 1'b1, 14101);
            push_ref(1'b1, 4'd6, 1'b1, 14102);
            push_ref(1'b1, 4'd5, 1'b1, 14103);
            push_ref(1'b1, 4'd4, 1'b1, 14104);
            push_ref(1'b1, 4'd3, 1'b1, 14105);
            ref_ack = 1'b1;
            goto_cycle(14105);
            ref_ack = 1'b0;

            goto_cycle(15599);
            push_ref(1'b1, 4'd4, 1'b1, 17160);
            ref_ack = 1'b1;
            goto_cycle(15600);
            ref_ack = 1'b0;
            chk("tick_ack_pending", 32'(ref_pending), 32'h3);

            goto_cycle(17200);
            push_seg(mk_seg(4'd9, 1'b1, 1'b1, 4'h7, 3'd0, 14'h0000, 1'b1), 17201);
            push_ref(1'b0, 4'd0, 1'b0, 17201);
            reinit = 1'b1;
            goto_cycle(17201);
            reinit = 1'b0;
            chk("reinit_step", 32'(step), 32'h0);
            chk("reinit_reset_n", 32'(ddr3_reset_n), 32'h0);
            goto_cycle(17220);
            seg_en = 1'b0;
            @(negedge clk);
            chk("seg_queue_drained", 32'(seg_q.size()), 32'h0);
            chk("ref_queue_drained", 32'(ref_q.size()), 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
